// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - dispense-motor handshake and coin-change sequencer
//
// Purpose: takes a confirmed purchase (or a cancel), runs the dispense motor,
// then returns change one coin unit at a time with a fixed pulse spacing.
// A motor that never acknowledges turns the purchase into a full refund and
// raises a sticky fault.
//
// Optional feature: define VEND_IDLE_TIMEOUT_EN to refund inserted money after
// IDLE_TIMEOUT cycles of inactivity in IDLE. Without it, funds are held.
//
// Ports:
//   clk          system clock, rising edge
//   rstn         synchronous reset, active HIGH (1 = reset)
//   buy_req      pulse: purchase confirmed (goods_index/price/paid sampled)
//   cancel_req   pulse: refund request (paid sampled); wins over buy_req
//   goods_index  selected item
//   price        item price
//   paid         money inserted
//   motor_ack    level: item dropped
//   motor_req    level: run motor (DISPENSE state)
//   motor_sel    latched goods index, valid while motor_req
//   coin_out     pulse: one coin unit returned
//   change_left  coin units still to return
//   busy         high outside IDLE
//   done         pulse: transaction finished
//   reject       pulse: buy_req with paid < price
//   fault        sticky: motor acknowledge timeout seen since reset

module vend_sequencer #(
  parameter int ACK_TIMEOUT  = 1023,
  parameter int COIN_GAP     = 16,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       buy_req,
  input  logic       cancel_req,
  input  logic [3:0] goods_index,
  input  logic [6:0] price,
  input  logic [6:0] paid,
  input  logic       motor_ack,
  output logic       motor_req,
  output logic [3:0] motor_sel,
  output logic       coin_out,
  output logic [6:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic       fault
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(COIN_GAP + 1);

  // DISPENSE gives up on the ACK_TIMEOUT-th cycle without an acknowledge.
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  // GAP lasts COIN_GAP-1 cycles so coin pulses are COIN_GAP cycles apart.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(COIN_GAP - 2);

  if (COIN_GAP < 2 || ACK_TIMEOUT < 1 || IDLE_TIMEOUT < 1) begin : g_cfg_check
    $error("vend_sequencer: COIN_GAP must be >= 2, ACK_TIMEOUT and IDLE_TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPENSE,
    S_CHANGE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [ACK_W-1:0] ack_cnt;
  logic [ACK_W-1:0] ack_cnt_nx;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nx;
  logic [6:0]       change_nx;
  logic [6:0]       paid_q;
  logic [6:0]       paid_nx;
  logic [3:0]       sel_nx;
  logic             reject_nx;
  logic             fault_nx;
  logic             refund_req;

`ifdef VEND_IDLE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic [6:0]        paid_seen;
  logic              idle_quiet;
  logic              idle_fire;

  // Money is waiting, nobody is asking for anything, and paid is unchanged.
  assign idle_quiet = (state == S_IDLE) && (paid != 7'd0) && (paid == paid_seen) &&
                      !buy_req && !cancel_req;
  assign idle_fire  = idle_quiet && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rstn) begin
      idle_cnt  <= '0;
      paid_seen <= '0;
    end else begin
      paid_seen <= paid;
      if (!idle_quiet || idle_fire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  // An inactivity expiry is handled exactly like a user cancel.
  assign refund_req = cancel_req || idle_fire;
`else
  assign refund_req = cancel_req;
`endif

  always_comb begin
    state_nx   = state;
    ack_cnt_nx = ack_cnt;
    gap_cnt_nx = gap_cnt;
    change_nx  = change_left;
    paid_nx    = paid_q;
    sel_nx     = motor_sel;
    reject_nx  = 1'b0;
    fault_nx   = fault;

    case (state)
      S_IDLE: begin
        // A cancel swallows a simultaneous buy, even when there is nothing to refund.
        if (refund_req) begin
          if (paid != 7'd0) begin
            change_nx = paid;
            state_nx  = S_CHANGE;
          end
        end else if (buy_req) begin
          if (paid >= price) begin
            sel_nx     = goods_index;
            change_nx  = paid - price;
            paid_nx    = paid;
            ack_cnt_nx = '0;
            state_nx   = S_DISPENSE;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        // Acknowledge takes priority over a timeout landing in the same cycle.
        if (motor_ack) begin
          state_nx = S_CHANGE;
        end else if (ack_cnt == ACK_LAST) begin
          fault_nx  = 1'b1;
          change_nx = paid_q;
          state_nx  = S_CHANGE;
        end else begin
          ack_cnt_nx = ack_cnt + ACK_W'(1);
        end
      end

      S_CHANGE: begin
        if (change_left == 7'd0) begin
          state_nx = S_DONE;
        end else begin
          change_nx  = change_left - 7'd1;
          gap_cnt_nx = '0;
          state_nx   = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = S_CHANGE;
        end else begin
          gap_cnt_nx = gap_cnt + GAP_W'(1);
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= S_IDLE;
      ack_cnt     <= '0;
      gap_cnt     <= '0;
      change_left <= '0;
      paid_q      <= '0;
      motor_sel   <= '0;
      reject      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      ack_cnt     <= ack_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      change_left <= change_nx;
      paid_q      <= paid_nx;
      motor_sel   <= sel_nx;
      reject      <= reject_nx;
      fault       <= fault_nx;
    end
  end

  assign motor_req = (state == S_DISPENSE);
  assign coin_out  = (state == S_CHANGE) && (change_left != 7'd0);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
